// File: rtl/core_mem_arb_pkg.sv
// core_mem_arb_pkg: shared state encodings and direction/boolean constants for the memory arbiter
package core_mem_arb_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
endpackage

// File: rtl/arb_priority_select.sv
// arb_priority_select: one-hot pick of the first requester at or after ptr, wrapping around
module arb_priority_select
    import core_mem_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);
    logic found;
    int   idx;
    always_comb begin
        grant = '0;
        found = FALSE;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                grant[idx] = TRUE;
                found      = TRUE;
            end
        end
    end
endmodule

// File: rtl/multi_port_memory_arbiter.sv
// multi_port_memory_arbiter: grants one port at a time to a shared burst memory interface.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module multi_port_memory_arbiter
    import core_mem_arb_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 21
) (
    input  logic                               i_Clk,
    input  logic                               i_Reset,
    input  logic [NUM_PORTS-1:0]               i_Port_Valid,
    input  logic [NUM_PORTS-1:0]               i_Port_Read_Write_n,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] i_Port_Address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    i_Port_Data,
    output logic [NUM_PORTS-1:0]               o_Port_Valid,
    output logic [NUM_PORTS-1:0]               o_Port_Data_Read,
    output logic [NUM_PORTS-1:0]               o_Port_Last,
    output logic [DATA_WIDTH-1:0]              o_Port_Data,
    output logic [NUM_PORTS-1:0]               o_Grant,
    output logic                               o_MEM_Valid,
    output logic [ADDRESS_WIDTH-1:0]           o_MEM_Address,
    output logic                               o_MEM_Read_Write_n,
    output logic [DATA_WIDTH-1:0]              o_MEM_Data,
    input  logic                               i_MEM_Data_Read,
    input  logic [DATA_WIDTH-1:0]              i_MEM_Data,
    input  logic                               i_MEM_Valid,
    input  logic                               i_MEM_Last
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_t               state;
    logic                 busy;
    logic                 start;
    logic [NUM_PORTS-1:0] win;
    logic [PW-1:0]        ptr;

    assign busy  = (state == BUSY);
    assign start = (state == IDLE) && (|i_Port_Valid);

    arb_priority_select #(.N(NUM_PORTS), .PW(PW)) u_select (
        .req   (i_Port_Valid),
        .ptr   (ptr),
        .grant (win)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [PW-1:0] nxt;
    always_comb begin
        nxt = '0;
        for (int k = 0; k < NUM_PORTS; k++)
            if (win[k]) nxt = PW'((k + 1) % NUM_PORTS);
    end
    always_ff @(posedge i_Clk or posedge i_Reset)
        if (i_Reset) ptr <= '0;
        else if (start) ptr <= nxt;
`else
    assign ptr = '0;
`endif

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state   <= IDLE;
            o_Grant <= '0;
        end else if (start) begin
            state   <= BUSY;
            o_Grant <= win;
        end else if (busy && i_MEM_Last) begin
            state   <= IDLE;
            o_Grant <= '0;
        end
    end

    // o_Grant is zero outside BUSY, so the AND-OR mux yields zeros when idle
    always_comb begin
        o_MEM_Address = '0;
        o_MEM_Data    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (o_Grant[k]) begin
                o_MEM_Address = o_MEM_Address | i_Port_Address[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                o_MEM_Data    = o_MEM_Data | i_Port_Data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_MEM_Valid        = busy;
    assign o_MEM_Read_Write_n = busy ? |(o_Grant & i_Port_Read_Write_n) : READ;
    assign o_Port_Valid       = (busy && i_MEM_Valid)     ? o_Grant : '0;
    assign o_Port_Data_Read   = (busy && i_MEM_Data_Read) ? o_Grant : '0;
    assign o_Port_Last        = (busy && i_MEM_Last)      ? o_Grant : '0;
    assign o_Port_Data        = i_MEM_Data;
endmodule

// File: tb/tb_multi_port_memory_arbiter.sv
// tb_multi_port_memory_arbiter: randomized self-checking bench against a queue-free arbitration model
module tb_multi_port_memory_arbiter;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int AW = 21;

    logic               i_Clk = 1'b0;
    logic               i_Reset;
    logic [NP-1:0]      i_Port_Valid;
    logic [NP-1:0]      i_Port_Read_Write_n;
    logic [NP*AW-1:0]   i_Port_Address;
    logic [NP*DW-1:0]   i_Port_Data;
    logic [NP-1:0]      o_Port_Valid;
    logic [NP-1:0]      o_Port_Data_Read;
    logic [NP-1:0]      o_Port_Last;
    logic [DW-1:0]      o_Port_Data;
    logic [NP-1:0]      o_Grant;
    logic               o_MEM_Valid;
    logic [AW-1:0]      o_MEM_Address;
    logic               o_MEM_Read_Write_n;
    logic [DW-1:0]      o_MEM_Data;
    logic               i_MEM_Data_Read;
    logic [DW-1:0]      i_MEM_Data;
    logic               i_MEM_Valid;
    logic               i_MEM_Last;

    int total = 0;
    int bad   = 0;
    int ptr_m = 0;

    logic [AW-1:0] addr_m [NP];
    logic [DW-1:0] data_m [NP];
    logic          rw_m   [NP];

    multi_port_memory_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .i_Clk               (i_Clk),
        .i_Reset             (i_Reset),
        .i_Port_Valid        (i_Port_Valid),
        .i_Port_Read_Write_n (i_Port_Read_Write_n),
        .i_Port_Address      (i_Port_Address),
        .i_Port_Data         (i_Port_Data),
        .o_Port_Valid        (o_Port_Valid),
        .o_Port_Data_Read    (o_Port_Data_Read),
        .o_Port_Last         (o_Port_Last),
        .o_Port_Data         (o_Port_Data),
        .o_Grant             (o_Grant),
        .o_MEM_Valid         (o_MEM_Valid),
        .o_MEM_Address       (o_MEM_Address),
        .o_MEM_Read_Write_n  (o_MEM_Read_Write_n),
        .o_MEM_Data          (o_MEM_Data),
        .i_MEM_Data_Read     (i_MEM_Data_Read),
        .i_MEM_Data          (i_MEM_Data),
        .i_MEM_Valid         (i_MEM_Valid),
        .i_MEM_Last          (i_MEM_Last)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick;
        @(posedge i_Clk);
        #1;
    endtask

    task automatic set_port(input int k, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rw_m[k]   = rw;
        addr_m[k] = a;
        data_m[k] = d;
        i_Port_Read_Write_n[k]   = rw;
        i_Port_Address[k*AW +: AW] = a;
        i_Port_Data[k*DW +: DW]    = d;
    endtask

    task automatic clear_mem;
        i_MEM_Valid     = 1'b0;
        i_MEM_Data_Read = 1'b0;
        i_MEM_Last      = 1'b0;
    endtask

    // Model: winner is the first requester scanning upward from ptr_m, wrapping.
    function automatic int pick(input logic [NP-1:0] req);
        for (int i = 0; i < NP; i++)
            if (req[(ptr_m + i) % NP]) return (ptr_m + i) % NP;
        return -1;
    endfunction

    // Serves one transaction for the expected winner; requests must already be driven.
    task automatic run_txn(input int exp, input int beats, input bit drop);
        logic [NP-1:0] oh;
        bit last;
        oh = NP'(1) << exp;
        tick;
        total++; if (o_Grant !== oh) begin bad++; $display("FAIL grant: got %b want %b", o_Grant, oh); end
        total++; if (o_MEM_Valid !== 1'b1) begin bad++; $display("FAIL mem_valid_busy: got %b want 1", o_MEM_Valid); end
        total++; if (o_MEM_Address !== addr_m[exp]) begin bad++; $display("FAIL mem_addr: got %h want %h", o_MEM_Address, addr_m[exp]); end
        total++; if (o_MEM_Read_Write_n !== rw_m[exp]) begin bad++; $display("FAIL mem_rw: got %b want %b", o_MEM_Read_Write_n, rw_m[exp]); end
        total++; if (o_MEM_Data !== data_m[exp]) begin bad++; $display("FAIL mem_data: got %h want %h", o_MEM_Data, data_m[exp]); end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ptr_m = (exp + 1) % NP;
`endif
        if (drop) i_Port_Valid[exp] = 1'b0;
        for (int b = 0; b < beats; b++) begin
            if ($urandom_range(0, 1) == 1) begin
                clear_mem();
                i_MEM_Data = $urandom;
                #1;
                total++; if (o_Port_Valid !== '0 || o_Port_Last !== '0 || o_Grant !== oh) begin
                    bad++; $display("FAIL gap: pv=%b pl=%b grant=%b want 0 0 %b", o_Port_Valid, o_Port_Last, o_Grant, oh);
                end
                tick;
            end
            last = (b == beats - 1);
            i_MEM_Valid     = rw_m[exp];
            i_MEM_Data_Read = !rw_m[exp];
            i_MEM_Last      = last;
            i_MEM_Data      = $urandom;
            #1;
            total++; if (o_Port_Valid !== (rw_m[exp] ? oh : '0)) begin bad++; $display("FAIL port_valid: got %b want %b", o_Port_Valid, rw_m[exp] ? oh : '0); end
            total++; if (o_Port_Data_Read !== (rw_m[exp] ? '0 : oh)) begin bad++; $display("FAIL port_data_read: got %b want %b", o_Port_Data_Read, rw_m[exp] ? '0 : oh); end
            total++; if (o_Port_Last !== (last ? oh : '0)) begin bad++; $display("FAIL port_last: got %b want %b", o_Port_Last, last ? oh : '0); end
            total++; if (o_Port_Data !== i_MEM_Data) begin bad++; $display("FAIL port_data: got %h want %h", o_Port_Data, i_MEM_Data); end
            tick;
            clear_mem();
        end
        total++; if (o_Grant !== '0 || o_MEM_Valid !== 1'b0) begin bad++; $display("FAIL idle_after_last: grant=%b mv=%b want 0 0", o_Grant, o_MEM_Valid); end
        total++; if (o_MEM_Read_Write_n !== 1'b1 || o_MEM_Address !== '0 || o_MEM_Data !== '0) begin
            bad++; $display("FAIL idle_mem_bus: rw=%b addr=%h data=%h want 1 0 0", o_MEM_Read_Write_n, o_MEM_Address, o_MEM_Data);
        end
    endtask

    task automatic test_reset;
        i_Reset = 1'b1;
        i_Port_Valid = '0;
        i_Port_Read_Write_n = '1;
        i_Port_Address = '0;
        i_Port_Data = '0;
        i_MEM_Data = '0;
        clear_mem();
        for (int k = 0; k < NP; k++) set_port(k, 1'b1, '0, '0);
        tick;
        tick;
        total++; if (o_Grant !== '0 || o_MEM_Valid !== 1'b0) begin bad++; $display("FAIL reset_state: grant=%b mv=%b want 0 0", o_Grant, o_MEM_Valid); end
        total++; if (o_Port_Valid !== '0 || o_Port_Data_Read !== '0 || o_Port_Last !== '0) begin
            bad++; $display("FAIL reset_ports: pv=%b pdr=%b pl=%b want 0", o_Port_Valid, o_Port_Data_Read, o_Port_Last);
        end
        total++; if (o_MEM_Read_Write_n !== 1'b1) begin bad++; $display("FAIL reset_rw: got %b want 1", o_MEM_Read_Write_n); end
        i_Reset = 1'b0;
        ptr_m = 0;
        tick;
    endtask

    task automatic test_single_read;
        set_port(2, 1'b1, 21'h1_2345, 32'hCAFE_0002);
        i_Port_Valid = 4'b0100;
        run_txn(pick(i_Port_Valid), 4, 1'b1);
    endtask

    task automatic test_priority;
        set_port(0, 1'b1, 21'h0_00A0, 32'h1111_0000);
        set_port(3, 1'b1, 21'h1_F003, 32'h3333_0003);
        i_Port_Valid = 4'b1001;
        run_txn(pick(i_Port_Valid), 2, 1'b1);
        run_txn(pick(i_Port_Valid), 3, 1'b1);
    endtask

    task automatic test_round_robin;
        for (int k = 0; k < NP; k++) set_port(k, 1'b1, AW'(k * 16 + 1), 32'hA000_0000 + k);
        i_Port_Valid = '1;
        for (int t = 0; t < 8; t++) run_txn(pick(i_Port_Valid), 1, 1'b0);
        i_Port_Valid = '0;
        tick;
    endtask

    task automatic test_write;
        set_port(1, 1'b0, 21'h0_BEEF, 32'hDEAD_0001);
        i_Port_Valid = 4'b0010;
        run_txn(pick(i_Port_Valid), 2, 1'b1);
    endtask

    task automatic test_reset_mid;
        set_port(0, 1'b1, 21'h0_0777, 32'h7777_7777);
        i_Port_Valid = 4'b0001;
        tick;
        i_Port_Valid = '0;
        i_MEM_Valid = 1'b1;
        tick;
        i_MEM_Valid = 1'b1;
        #1;
        i_Reset = 1'b1;
        #1;
        total++; if (o_MEM_Valid !== 1'b0 || o_Grant !== '0) begin bad++; $display("FAIL reset_mid: mv=%b grant=%b want 0 0", o_MEM_Valid, o_Grant); end
        i_MEM_Last = 1'b1;
        #1;
        total++; if (o_Port_Last !== '0 || o_Port_Valid !== '0) begin bad++; $display("FAIL reset_mid_ports: pl=%b pv=%b want 0 0", o_Port_Last, o_Port_Valid); end
        tick;
        clear_mem();
        i_Reset = 1'b0;
        ptr_m = 0;
        tick;
    endtask

    task automatic test_spurious_last;
        i_Port_Valid = '0;
        i_MEM_Last = 1'b1;
        i_MEM_Valid = 1'b1;
        i_MEM_Data_Read = 1'b1;
        #1;
        total++; if (o_Port_Valid !== '0 || o_Port_Last !== '0 || o_Port_Data_Read !== '0) begin
            bad++; $display("FAIL spurious_ports: pv=%b pl=%b pdr=%b want 0", o_Port_Valid, o_Port_Last, o_Port_Data_Read);
        end
        tick;
        tick;
        total++; if (o_Grant !== '0 || o_MEM_Valid !== 1'b0) begin bad++; $display("FAIL spurious_state: grant=%b mv=%b want 0 0", o_Grant, o_MEM_Valid); end
        clear_mem();
        set_port(3, 1'b1, 21'h1_0003, 32'h0000_0333);
        i_Port_Valid = 4'b1000;
        run_txn(pick(i_Port_Valid), 1, 1'b1);
    endtask

    task automatic test_random;
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < NP; k++) set_port(k, 1'($urandom), AW'($urandom), $urandom);
            i_Port_Valid = NP'($urandom_range(1, (1 << NP) - 1));
            run_txn(pick(i_Port_Valid), $urandom_range(1, 4), 1'($urandom));
        end
        i_Port_Valid = '0;
        tick;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_round_robin();
        test_write();
        test_reset_mid();
        test_spurious_last();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_port_memory_arbiter.md
MULTI_PORT_MEMORY_ARBITER -- requirements
Module: multi_port_memory_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requesting ports (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory data width.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 21, word-address width.
REQ-004 SHALL have a single clock and reset: one clock, reset asynchronous and active-high.
REQ-005 SHALL have ports:
- i_Clk  in  1  clock
- i_Reset  in  1  asynchronous active-high reset
- i_Port_Valid  in  NUM_PORTS  per-port request
- i_Port_Read_Write_n  in  NUM_PORTS  1=read, 0=write
- i_Port_Address  in  NUM_PORTS*ADDRESS_WIDTH  packed; port k at bits [k*AW +: AW]
- i_Port_Data  in  NUM_PORTS*DATA_WIDTH  packed write data
- o_Port_Valid  out  NUM_PORTS  read beat valid to granted port
- o_Port_Data_Read  out  NUM_PORTS  write beat consumed, granted port
- o_Port_Last  out  NUM_PORTS  last beat, granted port
- o_Port_Data  out  DATA_WIDTH  shared read data broadcast
- o_Grant  out  NUM_PORTS  one-hot current owner, registered
- o_MEM_Valid  out  1  memory request active
- o_MEM_Address  out  ADDRESS_WIDTH  granted port address
- o_MEM_Read_Write_n  out  1  granted port direction
- o_MEM_Data  out  DATA_WIDTH  granted port write data
- i_MEM_Data_Read  in  1  memory consumed write beat
- i_MEM_Data  in  DATA_WIDTH  read data
- i_MEM_Valid  in  1  read beat valid
- i_MEM_Last  in  1  last beat of transaction

Function
REQ-006 SHALL implement states IDLE and BUSY.
REQ-007 In IDLE with any i_Port_Valid set, SHALL select one winner, register o_Grant, and enter BUSY next edge (one-cycle grant latency).
REQ-008 In BUSY, SHALL drive o_MEM_Valid=1 and route the granted port's address, direction and write data to memory.
REQ-009 In BUSY, SHALL route i_MEM_Valid, i_MEM_Data_Read and i_MEM_Last only to the granted port's bit; all other port bits 0.
REQ-010 o_Port_Data SHALL equal i_MEM_Data combinationally at all times.
REQ-011 i_MEM_Last in BUSY SHALL return to IDLE next edge and clear o_Grant; no new grant is issued in that same cycle (one idle cycle between transactions).
REQ-012 i_MEM_Last, i_MEM_Valid and i_MEM_Data_Read in IDLE SHALL be ignored.
REQ-013 A granted port dropping i_Port_Valid mid-transaction SHALL NOT end the transaction; only i_MEM_Last ends it.
REQ-014 Requests on non-granted ports SHALL be held pending without effect until the next IDLE.
REQ-015 Outside BUSY, o_MEM_Valid=0, o_MEM_Read_Write_n=1, o_MEM_Address and o_MEM_Data=0.
REQ-016 o_Grant SHALL be one-hot or zero at all times.

Reset
REQ-017 Reset SHALL force IDLE, o_Grant=0, round-robin pointer=0, all port handshake outputs 0, o_MEM_Valid=0.
REQ-018 Reset asserted mid-transaction SHALL abandon it immediately; no o_Port_Last is generated.

Configuration
REQ-019 Macro MEM_ARB_ROUND_ROBIN_EN defined: winner is the first requester at or after (last winner+1) mod NUM_PORTS; pointer updates on grant.
REQ-020 Macro MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; no pointer register exists.

Structure
REQ-021 Package core_mem_arb_pkg SHALL hold state encodings, READ/WRITE and TRUE/FALSE constants.
REQ-022 Winner selection SHALL be sub-module arb_priority_select (request vector, pointer in; one-hot winner out), purely combinational.

Verification
REQ-023 Single port 2 read, 4-beat burst -> o_Grant=4'b0100 one cycle after request, o_Port_Valid[2] pulses four times, o_Port_Last[2] on beat 4, IDLE next edge.
REQ-024 Ports 0 and 3 request together, fixed priority -> port 0 served first, port 3 granted after one idle cycle.
REQ-025 Round-robin, all four ports hold requests for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-026 Port 1 write, 2 beats -> o_MEM_Read_Write_n=0, o_MEM_Data=port 1 data, o_Port_Data_Read[1] follows i_MEM_Data_Read.
REQ-027 Reset asserted during beat 2 of 4 -> o_MEM_Valid=0 and o_Grant=0 immediately, no o_Port_Last.
REQ-028 Spurious i_MEM_Last in IDLE -> no state change, all port outputs stay 0.
